redundancy_restorer: RTL
========================

// Module: redundancy_restorer
// PURPOSE
//  Consumer-side counterpart of the redundancy controller: rebuilds a full STEP_RANGE-wide
//  LIFM/result column from a dense column plus its mapping table (MT).
//  MT bit [STEP_RANGE*j + i] = 1 means output position j takes dense element i.
//  Sits after the PE array and scatters dense results back to original LIFM positions.
//  Scans LANES output positions per cycle: multi-cycle, one column in flight.
// PARAMETERS
//  WORD_WIDTH  8    bitwidth of one element (dense and restored)
//  STEP_RANGE  128  column length = MT row count = MT row width
//  LANES       8    output positions resolved per SCAN cycle; power of 2, divides STEP_RANGE
// PORTS
//  clk           in   1                      positive-edge clock
//  reset_n       in   1                      asynchronous active-low reset
//  enable_in     in   1                      load strobe; sampled only in IDLE
//  ready         out  1                      1 in IDLE (column can be loaded)
//  dense_column  in   WORD_WIDTH*STEP_RANGE  dense column; element i at [WORD_WIDTH*i +: WORD_WIDTH]
//  mt_column     in   STEP_RANGE*STEP_RANGE  mapping table; row j at [STEP_RANGE*j +: STEP_RANGE]
//  out_ready     in   1                      downstream accepts output
//  valid         out  1                      olifm_column is valid
//  olifm_column  out  WORD_WIDTH*STEP_RANGE  restored column; position j at [WORD_WIDTH*j +: WORD_WIDTH]
//  map_error     out  1                      1 if any MT row of the current column was illegal
// BEHAVIOUR
//  Reset: mode=IDLE, valid=0, map_error=0, olifm_column=0, all internal buffers and counters 0.
//  FSM: IDLE -> SCAN -> OUTPUT -> IDLE.
//   IDLE: ready=1. On enable_in: capture dense_column and mt_column into buffers; clear
//     map_error, scan counter and restored buffer; go to SCAN. enable_in outside IDLE is ignored.
//   SCAN: each cycle resolve positions j = LANES*cnt .. LANES*cnt+LANES-1.
//     out[j] = dense[i], i = lowest set bit of MT row j (priority encoder, LSB first).
//     Row j all zero: out[j] = 0, map_error set (sticky until next load).
//     cnt is $clog2(STEP_RANGE/LANES) bits. On last group (cnt == STEP_RANGE/LANES-1):
//     go to OUTPUT, valid<=1 on the same edge.
//   OUTPUT: valid=1; olifm_column and map_error held stable. On out_ready: valid<=0 -> IDLE.
//     Load in the same cycle is not possible: ready=0 in OUTPUT.
//  Latency: valid rises STEP_RANGE/LANES cycles after the capture edge (16 at defaults).
//  Throughput: one column per STEP_RANGE/LANES+2 cycles when out_ready is held 1.
//  olifm_column drives the restored buffer directly and keeps its last value in IDLE.
//  Reset asserted mid-SCAN/OUTPUT: immediate return to reset values; partial column discarded.
//  Element values pass through unmodified (no arithmetic, no width change).
// CONFIGURATION
//  RR_ONEHOT_CHECK_EN defined: a row with more than one set bit also sets map_error;
//   data selection stays lowest set bit.
//  Undefined: multi-hot rows resolve to lowest set bit silently; only empty rows set map_error.
// TESTING
//  1 identity MT (row j = bit j), dense[i]=i+1 -> after 16 cycles valid=1,
//    olifm[j]=j+1, map_error=0.
//  2 all rows = bit 0, dense[0]=8'hA5 -> every olifm element 8'hA5; row 5 zeroed
//    -> olifm[5]=0, map_error=1.
//  3 out_ready=0 for 10 cycles after valid -> valid, olifm, map_error stable, ready=0;
//    out_ready=1 -> next cycle valid=0, ready=1.
//  4 reset_n low at SCAN cycle 7 -> valid=0, olifm=0, map_error=0 immediately;
//    fresh load completes normally.
//  5 row 3 = bits 2 and 9, dense[2]=8'h11 -> olifm[3]=8'h11;
//    map_error=1 with RR_ONEHOT_CHECK_EN, 0 without.
//  6 enable_in pulsed during SCAN with new data -> ignored; output matches the first load.

Source files
------------

// File: rtl/redundancy_restorer.sv
// Purpose: scatters a dense column back to its original STEP_RANGE positions using a mapping table.
// Latency: valid rises STEP_RANGE/LANES cycles after the capture edge; one column in flight.
// Backpressure: holds valid/olifm_column/map_error in OUTPUT until out_ready; ready=0 outside IDLE.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   enable_in, ready  load strobe (sampled only in IDLE) / IDLE indicator
//   dense_column      dense input, element i at [WORD_WIDTH*i +: WORD_WIDTH]
//   mt_column         mapping table, row j at [STEP_RANGE*j +: STEP_RANGE];
//                     bit i of row j set means output position j takes dense element i
//   out_ready, valid  output handshake
//   olifm_column      restored column, position j at [WORD_WIDTH*j +: WORD_WIDTH]
//   map_error         sticky flag: some MT row of the current column was illegal
//
// Build option: RR_ONEHOT_CHECK_EN -- rows with more than one set bit also raise map_error
// (data selection is still the lowest set bit). Undefined: only empty rows raise map_error.

module redundancy_restorer #(
  parameter int WORD_WIDTH = 8,
  parameter int STEP_RANGE = 128,
  parameter int LANES      = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable_in,
  output logic                           ready,
  input  logic [WORD_WIDTH*STEP_RANGE-1:0] dense_column,
  input  logic [STEP_RANGE*STEP_RANGE-1:0] mt_column,
  input  logic                           out_ready,
  output logic                           valid,
  output logic [WORD_WIDTH*STEP_RANGE-1:0] olifm_column,
  output logic                           map_error
);

  localparam int GROUPS = STEP_RANGE / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int IDX_W  = (STEP_RANGE > 1) ? $clog2(STEP_RANGE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WORD_WIDTH*STEP_RANGE-1:0] dense_buf;
  logic [STEP_RANGE*STEP_RANGE-1:0] mt_buf;
  logic [WORD_WIDTH*STEP_RANGE-1:0] restored;
  logic [CNT_W-1:0]                 cnt;
  logic                             map_error_q;

  // Per-lane resolution of the group currently addressed by cnt.
  logic [STEP_RANGE-1:0] lane_row [LANES];
  logic [IDX_W-1:0]      lane_idx [LANES];
  logic [WORD_WIDTH-1:0] lane_val [LANES];
  logic [LANES-1:0]      lane_empty;
  logic [LANES-1:0]      lane_bad;
`ifdef RR_ONEHOT_CHECK_EN
  logic [LANES-1:0]      lane_multi;
`endif

  // Lowest set bit wins: scanning from the top down, the last hit overwrites earlier ones.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [STEP_RANGE-1:0] row);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = STEP_RANGE - 1; i >= 0; i--) begin
      if (row[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_row[l]   = mt_buf[STEP_RANGE*(int'(cnt)*LANES + l) +: STEP_RANGE];
      lane_idx[l]   = lowest_set(lane_row[l]);
      lane_empty[l] = ~|lane_row[l];
      // An empty row restores as zero rather than whatever element 0 happens to hold.
      lane_val[l]   = lane_empty[l] ? '0
                                    : dense_buf[WORD_WIDTH*int'(lane_idx[l]) +: WORD_WIDTH];
    end
  end

`ifdef RR_ONEHOT_CHECK_EN
  // row & (row - 1) clears the lowest set bit; anything left means more than one hot bit.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_multi[l] = |(lane_row[l] & (lane_row[l] - STEP_RANGE'(1)));
    end
  end
  assign lane_bad = lane_empty | lane_multi;
`else
  assign lane_bad = lane_empty;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable_in) state_nxt = SCAN;
      SCAN:    if (cnt == LAST_CNT) state_nxt = OUTPUT;
      OUTPUT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: valid is simply "in OUTPUT", so it rises on the same edge that leaves SCAN.
  always_comb begin
    ready = 1'b0;
    valid = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      OUTPUT:  valid = 1'b1;
      default: begin
        ready = 1'b0;
        valid = 1'b0;
      end
    endcase
  end

  // Datapath: capture, progressive scatter into the restored buffer, sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dense_buf   <= '0;
      mt_buf      <= '0;
      restored    <= '0;
      cnt         <= '0;
      map_error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_in) begin
            dense_buf   <= dense_column;
            mt_buf      <= mt_column;
            restored    <= '0;
            cnt         <= '0;
            map_error_q <= 1'b0;
          end
        end
        SCAN: begin
          for (int l = 0; l < LANES; l++) begin
            restored[WORD_WIDTH*(int'(cnt)*LANES + l) +: WORD_WIDTH] <= lane_val[l];
          end
          if (|lane_bad) map_error_q <= 1'b1;
          cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
        default: begin
          // OUTPUT: everything held stable for the consumer.
        end
      endcase
    end
  end

  // Output drives the buffer directly, so it keeps its value through IDLE.
  assign olifm_column = restored;
  assign map_error    = map_error_q;

endmodule
